spi_slave_shifter: RTL and testbench
====================================

// Module: spi_slave_shifter
// PURPOSE
//  SPI slave (target) end of the team's SPI link. Receives sclk/cs_n/mosi from an external master,
//  synchronises them into clk, and deserialises mosi into DATA_W-bit words. Serialises a buffered
//  tx word onto miso. Sits between the SPI pads and an APB-side register/FIFO block.
// PARAMETERS
//  DATA_W       8  word length, MSB first
//  CPOL         0  sclk idle level
//  CPHA         0  0: sample on leading edge, shift on trailing; 1: shift on leading, sample on trailing
//  SYNC_STAGES  2  synchroniser depth for sclk, cs_n, mosi (>=2)
// PORTS
//  clk          in   1       system clock; f_sclk <= f_clk/8 required
//  rst          in   1       synchronous, active-high reset
//  spi_sclk     in   1       SPI clock from master (async to clk)
//  spi_cs_n     in   1       chip select, active low (async)
//  spi_mosi     in   1       serial data in (async)
//  spi_miso     out  1       serial data out
//  spi_miso_oe  out  1       miso output enable (pad tristate control)
//  tx_data      in   DATA_W  next word to transmit
//  tx_valid     in   1       tx_data valid
//  tx_ready     out  1       tx holding buffer empty; tx_valid&tx_ready = accept
//  rx_data      out  DATA_W  last complete received word
//  rx_valid     out  1       1-cycle pulse, rx_data updated
//  tx_underrun  out  1       1-cycle pulse: word started with tx buffer empty (0x00 sent)
//  frame_start  out  1       1-cycle pulse on synced cs_n falling edge
//  frame_end    out  1       1-cycle pulse on synced cs_n rising edge
//  busy         out  1       state == ACTIVE
// BEHAVIOUR
//  Reset values: all outputs 0 except tx_ready=1; state=WAIT_IDLE; shift regs, bit_cnt, tx buffer cleared.
//  Sync: sclk/cs_n/mosi each through SYNC_STAGES flops (equal depth keeps them aligned); one further
//   flop on sclk_s/cs_s gives edges: rise=~d&s, fall=d&~s. lead = CPOL?fall:rise, trail = opposite.
//   sample_e = CPHA?trail:lead; shift_e = CPHA?lead:trail.
//  FSM: WAIT_IDLE -> IDLE when cs_s==1 (a frame in progress at reset release is ignored).
//   IDLE -> ACTIVE on cs fall: frame_start=1; bit_cnt=0; load tx_sh from buffer (tx_ready->1) or 0
//   with tx_underrun=1. CPHA=0: miso=tx_sh[MSB] immediately. CPHA=1: MSB is driven at first shift_e.
//   ACTIVE -> IDLE on cs rise: frame_end=1; partial rx word discarded (no rx_valid), bit_cnt=0.
//  ACTIVE, sample_e: rx_sh<={rx_sh[DATA_W-2:0],mosi_s}; bit_cnt++. When bit_cnt==DATA_W-1:
//   rx_data<=assembled word, rx_valid=1 next cycle, bit_cnt<=0, word_done<=1.
//  ACTIVE, shift_e: CPHA=0: if word_done, reload tx_sh from buffer (or 0 + tx_underrun), clear
//   word_done, drive new MSB; else shift tx_sh left, drive next bit. CPHA=1: if bit_cnt==0 and not
//   yet loaded for this word, reload as above and drive MSB; else shift left.
//  miso_oe = busy; miso = 0 when !busy. Latency sclk pin edge -> action = SYNC_STAGES+1 clk.
//  TX buffer: 1 entry; tx_ready = ~buf_full (registered, no same-cycle bypass). Accept and drain in
//   same cycle: drain takes old entry, new entry stored, tx_ready stays 0.
//  rx has no backpressure: consumer must take rx_data on rx_valid; next word overwrites.
//  cs rise and sample_e same cycle: cs rise wins, word discarded. rst mid-frame: immediate reset,
//   then WAIT_IDLE until cs_n seen high. bit_cnt width $clog2(DATA_W), wraps only via explicit clear.
// STRUCTURE
//  spi_pkg: typedef enum {WAIT_IDLE, IDLE, ACTIVE} spi_slv_state_e; mode helper functions
//   (lead/trail select from CPOL/CPHA); shared by master-side blocks.
//  Sub-module spi_sync_edge (SYNC_STAGES synchroniser + edge detect, outputs s/rise/fall), one
//   instance each for sclk and cs_n; mosi uses same module with edges unused.
// TESTING (bench models master: sclk period 16 clk, cs_n setup/hold 4 clk)
//  1 Mode0: preload tx 0x3C, send 0xA5 -> rx_valid once with rx_data=0xA5; miso bits 0,0,1,1,1,1,0,0.
//  2 Back-to-back 2 words, tx 0x81 then 0x7E loaded during word 1 -> rx 0x12,0x34; miso 0x81,0x7E.
//  3 No tx loaded, 1 word -> tx_underrun pulse at frame start, miso all 0, rx still correct.
//  4 cs_n high after 5 bits -> frame_end, no rx_valid; next full frame 0xC3 -> rx_data=0xC3.
//  5 rst pulse mid-word with cs_n still low -> WAIT_IDLE, no rx_valid until cs_n high then new frame.
//  6 CPOL=1,CPHA=1 build: send 0x5A, tx 0xF0 -> rx_data=0x5A, miso 1,1,1,1,0,0,0,0.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared SPI definitions: slave FSM states and
// CPOL/CPHA edge-selection helpers.
package spi_pkg;

  typedef enum logic [1:0] {
    WAIT_IDLE,
    IDLE,
    ACTIVE
  } spi_slv_state_e;

  function automatic logic lead_edge(
    input logic cpol,
    input logic rise,
    input logic fall
  );
    return cpol ? fall : rise;
  endfunction

  function automatic logic trail_edge(
    input logic cpol,
    input logic rise,
    input logic fall
  );
    return cpol ? rise : fall;
  endfunction

  function automatic logic sample_edge(
    input logic cpha,
    input logic lead,
    input logic trail
  );
    return cpha ? trail : lead;
  endfunction

  function automatic logic shift_edge(
    input logic cpha,
    input logic lead,
    input logic trail
  );
    return cpha ? lead : trail;
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchroniser for an async pin plus
// rise/fall detection on the synchronised value.
module spi_sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic s,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;
  logic              dly_q;
  logic              dly_d;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d};
    dly_d  = sync_q[STAGES-1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      dly_q  <= 1'b0;
    end else begin
      sync_q <= sync_d;
      dly_q  <= dly_d;
    end
  end

  assign s    = sync_q[STAGES-1];
  assign rise = ~dly_q & s;
  assign fall = dly_q & ~s;

endmodule

// File: rtl/spi_slave_shifter.sv
// SPI target: synchronises the pins into clk, deserialises
// mosi into words and serialises a buffered tx word onto miso.
module spi_slave_shifter
  import spi_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter bit CPOL        = 1'b0,
  parameter bit CPHA        = 1'b0,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              spi_sclk,
  input  logic              spi_cs_n,
  input  logic              spi_mosi,
  output logic              spi_miso,
  output logic              spi_miso_oe,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              tx_underrun,
  output logic              frame_start,
  output logic              frame_end,
  output logic              busy
);

  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_W - 1);

  logic sclk_rise;
  logic sclk_fall;
  logic unused_sclk_s;
  logic cs_s;
  logic cs_rise;
  logic cs_fall;
  logic mosi_s;
  logic unused_mosi_rise;
  logic unused_mosi_fall;

  spi_sync_edge #(.STAGES(SYNC_STAGES)) u_sclk (
    .clk  (clk),
    .rst  (rst),
    .d    (spi_sclk),
    .s    (unused_sclk_s),
    .rise (sclk_rise),
    .fall (sclk_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES)) u_cs (
    .clk  (clk),
    .rst  (rst),
    .d    (spi_cs_n),
    .s    (cs_s),
    .rise (cs_rise),
    .fall (cs_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES)) u_mosi (
    .clk  (clk),
    .rst  (rst),
    .d    (spi_mosi),
    .s    (mosi_s),
    .rise (unused_mosi_rise),
    .fall (unused_mosi_fall)
  );

  logic lead;
  logic trail;
  logic sample_e;
  logic shift_e;

  assign lead     = lead_edge(CPOL, sclk_rise, sclk_fall);
  assign trail    = trail_edge(CPOL, sclk_rise, sclk_fall);
  assign sample_e = sample_edge(CPHA, lead, trail);
  assign shift_e  = shift_edge(CPHA, lead, trail);

  spi_slv_state_e    state_q, state_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0] rx_sh_q, rx_sh_d;
  logic [DATA_W-1:0] tx_sh_q, tx_sh_d;
  logic [DATA_W-1:0] rx_data_q, rx_data_d;
  logic [DATA_W-1:0] buf_q, buf_d;
  logic              buf_full_q, buf_full_d;
  logic              rx_valid_q, rx_valid_d;
  logic              unr_q, unr_d;
  logic              fs_q, fs_d;
  logic              fe_q, fe_d;
  logic              word_done_q, word_done_d;
  logic              pend_q, pend_d;
  logic              miso_q, miso_d;
  logic              load;
  logic              accept;
  logic [DATA_W-1:0] load_word;

  assign load_word = buf_full_q ? buf_q : '0;

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    rx_sh_d     = rx_sh_q;
    tx_sh_d     = tx_sh_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    unr_d       = 1'b0;
    fs_d        = 1'b0;
    fe_d        = 1'b0;
    word_done_d = word_done_q;
    pend_d      = pend_q;
    miso_d      = miso_q;
    load        = 1'b0;
    unique case (state_q)
      WAIT_IDLE: begin
        if (cs_s) state_d = IDLE;
      end
      IDLE: begin
        if (cs_fall) begin
          state_d     = ACTIVE;
          fs_d        = 1'b1;
          bit_cnt_d   = '0;
          word_done_d = 1'b0;
          load        = 1'b1;
          tx_sh_d     = load_word;
          unr_d       = ~buf_full_q;
          // CPHA=1 holds the MSB back until the first shift edge
          pend_d      = CPHA;
          miso_d      = CPHA ? 1'b0 : load_word[DATA_W-1];
        end
      end
      ACTIVE: begin
        if (cs_rise) begin
          state_d     = IDLE;
          fe_d        = 1'b1;
          bit_cnt_d   = '0;
          word_done_d = 1'b0;
          pend_d      = 1'b0;
          miso_d      = 1'b0;
        end else begin
          if (sample_e) begin
            rx_sh_d = {rx_sh_q[DATA_W-2:0], mosi_s};
            if (bit_cnt_q == LAST) begin
              rx_data_d   = rx_sh_d;
              rx_valid_d  = 1'b1;
              bit_cnt_d   = '0;
              word_done_d = 1'b1;
            end else begin
              bit_cnt_d = bit_cnt_q + 1'b1;
            end
          end
          if (shift_e) begin
            if (!CPHA && word_done_q) begin
              load        = 1'b1;
              tx_sh_d     = load_word;
              unr_d       = ~buf_full_q;
              miso_d      = load_word[DATA_W-1];
              word_done_d = 1'b0;
            end else if (CPHA && bit_cnt_q == '0 && pend_q) begin
              miso_d = tx_sh_q[DATA_W-1];
              pend_d = 1'b0;
            end else if (CPHA && bit_cnt_q == '0) begin
              load    = 1'b1;
              tx_sh_d = load_word;
              unr_d   = ~buf_full_q;
              miso_d  = load_word[DATA_W-1];
            end else begin
              tx_sh_d = {tx_sh_q[DATA_W-2:0], 1'b0};
              miso_d  = tx_sh_q[DATA_W-2];
            end
          end
        end
      end
      default: state_d = WAIT_IDLE;
    endcase
  end

  // Accept only into an empty slot; a load drains whatever is held
  always_comb begin
    accept     = tx_valid & ~buf_full_q;
    buf_d      = accept ? tx_data : buf_q;
    buf_full_d = accept | (buf_full_q & ~load);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= WAIT_IDLE;
      bit_cnt_q   <= '0;
      rx_sh_q     <= '0;
      tx_sh_q     <= '0;
      rx_data_q   <= '0;
      buf_q       <= '0;
      buf_full_q  <= 1'b0;
      rx_valid_q  <= 1'b0;
      unr_q       <= 1'b0;
      fs_q        <= 1'b0;
      fe_q        <= 1'b0;
      word_done_q <= 1'b0;
      pend_q      <= 1'b0;
      miso_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      rx_sh_q     <= rx_sh_d;
      tx_sh_q     <= tx_sh_d;
      rx_data_q   <= rx_data_d;
      buf_q       <= buf_d;
      buf_full_q  <= buf_full_d;
      rx_valid_q  <= rx_valid_d;
      unr_q       <= unr_d;
      fs_q        <= fs_d;
      fe_q        <= fe_d;
      word_done_q <= word_done_d;
      pend_q      <= pend_d;
      miso_q      <= miso_d;
    end
  end

  assign busy        = (state_q == ACTIVE);
  assign spi_miso_oe = busy;
  assign spi_miso    = busy & miso_q;
  assign tx_ready    = ~buf_full_q;
  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign tx_underrun = unr_q;
  assign frame_start = fs_q;
  assign frame_end   = fe_q;

endmodule

// File: tb/tb_spi_slave_shifter.sv
// Bench for spi_slave_shifter: mode-0 and mode-3 instances
// driven by a modelled SPI master, scoreboarded rx/miso words.
module tb_spi_slave_shifter;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] sclk;
  logic [1:0] cs_n;
  logic [1:0] mosi;
  logic [1:0] miso;
  logic [1:0] miso_oe;
  logic [1:0] tx_valid;
  logic [1:0] tx_ready;
  logic [1:0] rx_valid;
  logic [1:0] tx_underrun;
  logic [1:0] frame_start;
  logic [1:0] frame_end;
  logic [1:0] busy;
  logic [7:0] tx_data [2];
  logic [7:0] rx_data [2];

  always #5 clk = ~clk;

  spi_slave_shifter #(.CPOL(1'b0), .CPHA(1'b0)) u_m0 (
    .clk(clk), .rst(rst),
    .spi_sclk(sclk[0]), .spi_cs_n(cs_n[0]), .spi_mosi(mosi[0]),
    .spi_miso(miso[0]), .spi_miso_oe(miso_oe[0]),
    .tx_data(tx_data[0]), .tx_valid(tx_valid[0]),
    .tx_ready(tx_ready[0]), .rx_data(rx_data[0]),
    .rx_valid(rx_valid[0]), .tx_underrun(tx_underrun[0]),
    .frame_start(frame_start[0]), .frame_end(frame_end[0]),
    .busy(busy[0])
  );

  spi_slave_shifter #(.CPOL(1'b1), .CPHA(1'b1)) u_m3 (
    .clk(clk), .rst(rst),
    .spi_sclk(sclk[1]), .spi_cs_n(cs_n[1]), .spi_mosi(mosi[1]),
    .spi_miso(miso[1]), .spi_miso_oe(miso_oe[1]),
    .tx_data(tx_data[1]), .tx_valid(tx_valid[1]),
    .tx_ready(tx_ready[1]), .rx_data(rx_data[1]),
    .rx_valid(rx_valid[1]), .tx_underrun(tx_underrun[1]),
    .frame_start(frame_start[1]), .frame_end(frame_end[1]),
    .busy(busy[1])
  );

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_rx[$];
  logic [7:0] exp_mi[$];
  logic [7:0] txq0[$];
  logic [7:0] txq1[$];
  int unr_cnt [2] = '{0, 0};
  int fs_cnt  [2] = '{0, 0};
  int fe_cnt  [2] = '{0, 0};
  int exp_unr [2] = '{0, 0};
  int exp_fs  [2] = '{0, 0};
  int exp_fe  [2] = '{0, 0};
  logic [7:0] mi_sh [2];
  int mi_n [2] = '{0, 0};

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %0h expected %0h", name, act, exp);
    end
  endtask

  // rx scoreboard and pulse counters
  always @(negedge clk) begin
    logic [7:0] e;
    for (int m = 0; m < 2; m++) begin
      if (tx_underrun[m] === 1'b1) unr_cnt[m]++;
      if (frame_start[m] === 1'b1) fs_cnt[m]++;
      if (frame_end[m] === 1'b1) fe_cnt[m]++;
      if (rx_valid[m] === 1'b1) begin
        checks++;
        if (exp_rx.size() == 0) begin
          errors++;
          $display("FAIL rx_unexpected dut%0d actual %02h expected none",
                   m, rx_data[m]);
        end else begin
          e = exp_rx.pop_front();
          if (rx_data[m] !== e) begin
            errors++;
            $display("FAIL rx_data dut%0d actual %02h expected %02h",
                     m, rx_data[m], e);
          end
        end
      end
    end
  end

  // miso monitor: master-side sample edge is a rising sclk in both modes
  task automatic mi_bit(input int m, input logic b);
    logic [7:0] e;
    mi_sh[m] = {mi_sh[m][6:0], b};
    mi_n[m]++;
    if (mi_n[m] == 8) begin
      mi_n[m] = 0;
      checks++;
      if (exp_mi.size() == 0) begin
        errors++;
        $display("FAIL miso_unexpected dut%0d actual %02h expected none",
                 m, mi_sh[m]);
      end else begin
        e = exp_mi.pop_front();
        if (mi_sh[m] !== e) begin
          errors++;
          $display("FAIL miso_word dut%0d actual %02h expected %02h",
                   m, mi_sh[m], e);
        end
      end
    end
  endtask

  always @(posedge sclk[0]) if (cs_n[0] === 1'b0) mi_bit(0, miso[0]);
  always @(posedge sclk[1]) if (cs_n[1] === 1'b0) mi_bit(1, miso[1]);
  always @(posedge cs_n[0]) mi_n[0] = 0;
  always @(posedge cs_n[1]) mi_n[1] = 0;

  // Reference: a frame fetches one tx word at its start and then one
  // per completed word (mode 0) or one per started word (mode 3).
  task automatic expect_frame(input int m, input logic [15:0] mo,
                              input int nb);
    int nw;
    int loads;
    logic [7:0] v;
    nw = nb / 8;
    loads = (m == 0) ? 1 + nw : (nb + 7) / 8;
    for (int k = 0; k < nw; k++) exp_rx.push_back(mo[15-8*k -: 8]);
    for (int k = 0; k < loads; k++) begin
      if (m == 0 && txq0.size() != 0) v = txq0.pop_front();
      else if (m == 1 && txq1.size() != 0) v = txq1.pop_front();
      else begin
        v = 8'h00;
        exp_unr[m]++;
      end
      if (k < nw) exp_mi.push_back(v);
    end
    exp_fs[m]++;
    exp_fe[m]++;
  endtask

  task automatic push_tx(input int m, input logic [7:0] v);
    int t;
    t = 0;
    while (tx_ready[m] !== 1'b1 && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (tx_ready[m] !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL tx_ready_timeout dut%0d actual 0 expected 1", m);
    end
    tx_data[m]  = v;
    tx_valid[m] = 1'b1;
    @(negedge clk);
    tx_valid[m] = 1'b0;
  endtask

  task automatic frame(input int m, input logic [15:0] mo, input int nb);
    @(negedge clk);
    cs_n[m] = 1'b0;
    if (m == 0) mosi[m] = mo[15];
    repeat (4) @(negedge clk);
    for (int i = 0; i < nb; i++) begin
      if (m == 1) begin
        sclk[m] = 1'b0;
        mosi[m] = mo[15-i];
        repeat (8) @(negedge clk);
        sclk[m] = 1'b1;
        repeat (8) @(negedge clk);
      end else begin
        sclk[m] = 1'b1;
        repeat (8) @(negedge clk);
        sclk[m] = 1'b0;
        if (i + 1 < nb) mosi[m] = mo[14-i];
        repeat (8) @(negedge clk);
      end
    end
    repeat (4) @(negedge clk);
    cs_n[m] = 1'b1;
    mosi[m] = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic end_test(input int m, input string tag);
    chk({tag, "_underruns"}, unr_cnt[m], exp_unr[m]);
    chk({tag, "_frame_starts"}, fs_cnt[m], exp_fs[m]);
    chk({tag, "_frame_ends"}, fe_cnt[m], exp_fe[m]);
    chk({tag, "_rx_missing"}, exp_rx.size(), 0);
    chk({tag, "_miso_missing"}, exp_mi.size(), 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog actual timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int m;
    int nw;
    logic [15:0] d;
    rst = 1'b1;
    sclk = 2'b10;
    cs_n = 2'b11;
    mosi = 2'b00;
    tx_valid = 2'b00;
    tx_data[0] = 8'h00;
    tx_data[1] = 8'h00;
    repeat (4) @(negedge clk);
    chk("rst_tx_ready", tx_ready, 2'b11);
    chk("rst_busy", busy, 2'b00);
    chk("rst_miso_oe", miso_oe, 2'b00);
    chk("rst_miso", miso, 2'b00);
    chk("rst_rx_valid", rx_valid, 2'b00);
    chk("rst_pulses", {tx_underrun, frame_start, frame_end}, 6'd0);
    chk("rst_rx_data", {rx_data[0], rx_data[1]}, 16'h0000);
    rst = 1'b0;
    repeat (10) @(negedge clk);

    txq0.push_back(8'h3C);
    push_tx(0, 8'h3C);
    chk("t1_tx_ready_full", tx_ready[0], 1'b0);
    expect_frame(0, 16'hA500, 8);
    frame(0, 16'hA500, 8);
    end_test(0, "t1");

    txq0.push_back(8'h81);
    txq0.push_back(8'h7E);
    push_tx(0, 8'h81);
    expect_frame(0, 16'h1234, 16);
    fork
      frame(0, 16'h1234, 16);
      begin
        repeat (40) @(negedge clk);
        push_tx(0, 8'h7E);
      end
    join
    end_test(0, "t2");

    expect_frame(0, 16'h5D00, 8);
    frame(0, 16'h5D00, 8);
    end_test(0, "t3");

    expect_frame(0, 16'hB800, 5);
    frame(0, 16'hB800, 5);
    txq0.push_back(8'h55);
    push_tx(0, 8'h55);
    expect_frame(0, 16'hC300, 8);
    frame(0, 16'hC300, 8);
    end_test(0, "t4");

    // reset mid-word with cs_n held low
    exp_unr[0]++;
    exp_fs[0]++;
    @(negedge clk);
    cs_n[0] = 1'b0;
    mosi[0] = 1'b1;
    repeat (4) @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      if (i == 3) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("t5_busy_after_rst", busy[0], 1'b0);
        chk("t5_oe_after_rst", miso_oe[0], 1'b0);
        chk("t5_tx_ready_after_rst", tx_ready[0], 1'b1);
      end
      sclk[0] = 1'b1;
      repeat (8) @(negedge clk);
      sclk[0] = 1'b0;
      mosi[0] = ~mosi[0];
      repeat (8) @(negedge clk);
    end
    chk("t5_busy_cs_low", busy[0], 1'b0);
    cs_n[0] = 1'b1;
    mosi[0] = 1'b0;
    repeat (8) @(negedge clk);
    txq0.push_back(8'h69);
    push_tx(0, 8'h69);
    expect_frame(0, 16'h9600, 8);
    frame(0, 16'h9600, 8);
    end_test(0, "t5");

    txq1.push_back(8'hF0);
    push_tx(1, 8'hF0);
    expect_frame(1, 16'h5A00, 8);
    frame(1, 16'h5A00, 8);
    end_test(1, "t6");

    for (int r = 0; r < 8; r++) begin
      m = r % 2;
      nw = $urandom_range(1, 2);
      d = 16'($urandom);
      if (nw == 2 || $urandom_range(0, 1) == 1) begin
        if (m == 0) txq0.push_back(d[7:0] ^ 8'hA3);
        else txq1.push_back(d[7:0] ^ 8'hA3);
        push_tx(m, d[7:0] ^ 8'hA3);
      end
      if (nw == 2) begin
        if (m == 0) txq0.push_back(d[15:8] ^ 8'h5C);
        else txq1.push_back(d[15:8] ^ 8'h5C);
      end
      expect_frame(m, d, 8 * nw);
      fork
        frame(m, d, 8 * nw);
        begin
          if (nw == 2) begin
            repeat (40) @(negedge clk);
            push_tx(m, d[15:8] ^ 8'h5C);
          end
        end
      join
      end_test(m, "rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
